// File: rtl/wb_drain.sv
// Writeback drain queue: buffers memory-stage results and issues one regfile write per cycle.
// Optional forwarding compare logic is built only when WB_FWD_EN is defined.
module wb_drain #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_we,
  input  logic [2:0]    in_rd,
  input  logic [7:0]    in_data,
  input  logic          hold,
  output logic          RegWrite,
  output logic [2:0]    RDo,
  output logic [7:0]    Mem_to_Reg,
  input  logic [2:0]    qa,
  input  logic [2:0]    qb,
  output logic          fwd_a_hit,
  output logic          fwd_b_hit,
  output logic [7:0]    fwd_a,
  output logic [7:0]    fwd_b,
  output logic [CW-1:0] count
);

  logic [2:0]    mem_rd   [DEPTH];
  logic [7:0]    mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          enq;
  logic          pop;

  // Handshake: a transfer happens at any edge where in_valid && in_ready; in_ready
  // depends only on rst/count, so a full queue refuses even if it pops that edge.
  assign in_ready = !rst && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign enq      = push && in_we && (in_rd != 3'd0);
  assign pop      = !hold && (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      RegWrite   <= 1'b0;
      RDo        <= 3'd0;
      Mem_to_Reg <= 8'd0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        RDo        <= mem_rd[rd_ptr];
        Mem_to_Reg <= mem_data[rd_ptr];
      end
      RegWrite <= pop;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_rd[wr_ptr]   <= in_rd;
      mem_data[wr_ptr] <= in_data;
    end
  end

`ifdef WB_FWD_EN
  // Scan oldest to youngest so younger matches overwrite; output register is lowest priority.
  function automatic logic [8:0] lookup(input logic [2:0] q);
    logic [8:0]    r;
    logic [PW-1:0] idx;
    r = '0;
    if (q != 3'd0) begin
      if (RegWrite && (RDo == q)) r = {1'b1, Mem_to_Reg};
      for (int i = DEPTH - 1; i >= 0; i--) begin
        idx = wr_ptr - PW'(i + 1);
        if ((CW'(i) < count) && (mem_rd[idx] == q)) r = {1'b1, mem_data[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {fwd_a_hit, fwd_a} = lookup(qa);
    {fwd_b_hit, fwd_b} = lookup(qb);
  end
`else
  logic unused_q;
  assign unused_q  = ^{qa, qb};
  assign fwd_a_hit = 1'b0;
  assign fwd_b_hit = 1'b0;
  assign fwd_a     = 8'd0;
  assign fwd_b     = 8'd0;
`endif

endmodule

// File: doc/wb_drain.md
# wb_drain

Writeback drain queue sitting between the memory stage and the 8-entry, 8-bit register file write port. It accepts completed results from the memory stage over a valid/ready handshake and buffers them in a small FIFO. It issues exactly one register write per cycle on the register file's `RegWrite`/`RDo`/`Mem_to_Reg` port. It also provides forwarding lookups so the read side never sees stale operands for writes still in flight.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  memory stage presents a result.
- `in_ready`  out  1  queue can accept this cycle.
- `in_we`  in  1  result targets a register (0 = no writeback).
- `in_rd`  in  3  destination register.
- `in_data`  in  8  result value.
- `hold`  in  1  freeze draining (regfile port unavailable).
- `RegWrite`  out  1  registered write strobe to the register file.
- `RDo`  out  3  registered write address.
- `Mem_to_Reg`  out  8  registered write data.
- `qa`, `qb`  in  3 each  forwarding query addresses (the regfile `RA`/`RB`).
- `fwd_a_hit`, `fwd_b_hit`  out  1 each  query matches an in-flight write.
- `fwd_a`, `fwd_b`  out  8 each  forwarded value (0 when no hit).
- `count`  out  clog2(DEPTH+1)  occupied entries.

## Operation
- Handshake: a transfer occurs at an edge where `in_valid && in_ready`. `in_ready = !rst && count < DEPTH`. A full queue does not accept, even if a pop happens in the same cycle.
- Transfer with `in_we=0` or `in_rd=0` is consumed but not enqueued. r0 reads as zero, so writes to it are discarded.
- Otherwise `{in_rd,in_data}` is written at `wr_ptr` and `wr_ptr` increments modulo DEPTH.
- Drain at each edge:
  - If `!hold` and count>0, the head entry is loaded into `RDo`/`Mem_to_Reg`, `RegWrite<=1`, and `rd_ptr` increments.
  - Otherwise `RegWrite<=0`. `RDo`/`Mem_to_Reg` hold their last values.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Push while empty: the entry is not popped in the same edge. It is eligible at the next edge.
- Forwarding (combinational), per query port:
  - Priority is youngest queue entry, then older queue entries, then the output register when `RegWrite=1`.
  - A query of 0 never hits.
  - Pointer wrap-around must be handled in the age ordering.
- Reset: pointers 0, count 0, `RegWrite=0`, `RDo=0`, `Mem_to_Reg=0`, all hits 0.
- Reset mid-operation discards every pending entry, and no write is issued for them.

## Timing
- Accept at edge N → earliest `RegWrite=1` with that entry during the cycle after edge N+1. The register file commits it at edge N+2.
- Throughput: one write per cycle while `!hold` and non-empty.
- `in_ready` is combinational from `count`/`rst` only. It has no path from `in_valid`.
- Forward outputs are combinational from `qa`/`qb` and state, valid in the same cycle.
- `hold` asserted at edge M: no pop at M, `RegWrite=0` from M. Deassert at edge K: pop resumes at K.

## Configuration
- `WB_FWD_EN` defined: forwarding logic as above.
- `WB_FWD_EN` undefined: no compare logic is built. `fwd_a_hit`/`fwd_b_hit`/`fwd_a`/`fwd_b` are tied to 0. The pipeline must then stall until `count==0 && !RegWrite` before reading a pending register.

## Test plan
- Reset, then push `{rd=3,data=8'hA5}` at edge 1 → `RegWrite=1, RDo=3, Mem_to_Reg=A5` after edge 2, `RegWrite=0` after edge 3, `count=0`.
- `hold=1` and push 4 entries (rd 1..4, data 11..44) → `count=4`, `in_ready=0`, a 5th `in_valid` is not accepted. Release `hold` → writes 1..4 in order on 4 consecutive cycles.
- Push `rd=0,data=FF` and `in_we=0,rd=5` → both accepted, `count` stays 0, `RegWrite` never asserts.
- With `WB_FWD_EN`, queue `{2,10}` then `{2,20}` under hold, `qa=2` → `fwd_a_hit=1, fwd_a=20`. `qb=0` → `fwd_b_hit=0`.
- Fill, drain 3, and refill across pointer wrap → FIFO order preserved and forwarding still selects the youngest entry. Sustained push+pop at count=2 keeps count=2.
- Assert `rst` with 3 entries pending → `RegWrite=0` after that edge, `count=0`, no pending entry ever written.
